// File: rtl/bnn_pkg.sv
// Shared constants and FSM state encoding for the BNN weight loader.
// BNN_LOAD_CHECKSUM_EN adds the checksum trailer states.
package bnn_pkg;

  localparam int NUM_NEURONS_DEF = 12;
  localparam int WEIGHT_W        = 8;
  localparam int NIB_W           = 4;
  localparam int STATE_W         = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LO     = 3'd1;
  localparam logic [2:0] S_HI     = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd6;
`ifdef BNN_LOAD_CHECKSUM_EN
  localparam logic [2:0] S_CHK_LO = 3'd4;
  localparam logic [2:0] S_CHK_HI = 3'd5;
`endif

endpackage

// File: rtl/bnn_nibble_packer.sv
// Low/high nibble latch and weight byte assembly.
// BNN_LOAD_CHECKSUM_EN exposes the unlatched candidate byte.
module bnn_nibble_packer
  import bnn_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                i_ld_lo,
  input  logic                i_ld_hi,
  input  logic [NIB_W-1:0]    i_nib,
`ifdef BNN_LOAD_CHECKSUM_EN
  output logic [WEIGHT_W-1:0] o_cand,
`endif
  output logic [WEIGHT_W-1:0] o_byte
);

  logic [NIB_W-1:0]    r_lo;
  logic [WEIGHT_W-1:0] r_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo   <= '0;
      r_byte <= '0;
    end else begin
      if (i_ld_lo)
        r_lo <= i_nib;
      if (i_ld_hi)
        r_byte <= {i_nib, r_lo};
    end
  end

`ifdef BNN_LOAD_CHECKSUM_EN
  assign o_cand = {i_nib, r_lo};
`endif
  assign o_byte = r_byte;

endmodule

// File: rtl/bnn_load_ctrl.sv
// Nibble-serial weight load controller for the BNN register file.
// BNN_LOAD_CHECKSUM_EN adds an XOR checksum trailer check.
module bnn_load_ctrl
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = NUM_NEURONS_DEF,
  parameter int ADDR_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                start,
  input  logic                abort,
  input  logic                nib_valid,
  input  logic [NIB_W-1:0]    nib_data,
  output logic                nib_ready,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [WEIGHT_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic                weights_valid,
  output logic                err
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_wv;
  logic                r_err;
  logic                w_go;
  logic                w_abort;
  logic                w_hs;
  logic                w_last;
  logic                w_rdy_st;
  logic                w_ld_lo;
  logic                w_ld_hi;
  logic [WEIGHT_W-1:0] w_byte;

  assign w_go    = ena & start & (r_state == S_IDLE);
  assign w_abort = ena & abort & (r_state != S_IDLE);
  assign w_last  = (r_cnt == LAST);

  assign w_rdy_st = (r_state == S_LO)
                  | (r_state == S_HI)
`ifdef BNN_LOAD_CHECKSUM_EN
                  | (r_state == S_CHK_LO)
                  | (r_state == S_CHK_HI)
`endif
                  ;

  assign nib_ready = ena & w_rdy_st;
  assign w_hs      = nib_valid & nib_ready;

  // abort wins over any handshake landing in the same cycle
  assign w_ld_lo = w_hs & ~w_abort
                 & ((r_state == S_LO)
`ifdef BNN_LOAD_CHECKSUM_EN
                 | (r_state == S_CHK_LO)
`endif
                 );
  assign w_ld_hi = w_hs & ~w_abort & (r_state == S_HI);

`ifdef BNN_LOAD_CHECKSUM_EN
  logic [WEIGHT_W-1:0] r_csum;
  logic [WEIGHT_W-1:0] w_cand;
  logic                w_chk_ok;

  assign w_chk_ok = (w_cand == r_csum);
`endif

  bnn_nibble_packer u_packer (
    .clk     (clk),
    .reset   (reset),
    .i_ld_lo (w_ld_lo),
    .i_ld_hi (w_ld_hi),
    .i_nib   (nib_data),
`ifdef BNN_LOAD_CHECKSUM_EN
    .o_cand  (w_cand),
`endif
    .o_byte  (w_byte)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:
        if (start)
          w_next = S_LO;
      S_LO:
        if (w_hs)
          w_next = S_HI;
      S_HI:
        if (w_hs)
          w_next = S_WRITE;
      S_WRITE:
        if (!w_last)
          w_next = S_LO;
        else
`ifdef BNN_LOAD_CHECKSUM_EN
          w_next = S_CHK_LO;
`else
          w_next = S_DONE;
`endif
`ifdef BNN_LOAD_CHECKSUM_EN
      S_CHK_LO:
        if (w_hs)
          w_next = S_CHK_HI;
      S_CHK_HI:
        if (w_hs)
          w_next = w_chk_ok ? S_DONE : S_IDLE;
`endif
      S_DONE:
        w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
    if (w_abort)
      w_next = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else if (ena)
      r_state <= w_next;
  end

  // counter saturates at the last neuron so it can never wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (w_go)
      r_cnt <= '0;
    else if (wr_en && !w_last)
      r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wv  <= 1'b1;
      r_err <= 1'b0;
    end else if (w_go) begin
      r_wv  <= 1'b0;
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end else if (ena && r_state == S_DONE) begin
      r_wv  <= 1'b1;
`ifdef BNN_LOAD_CHECKSUM_EN
    end else if (ena && r_state == S_CHK_HI
                 && w_hs && !w_chk_ok) begin
      r_err <= 1'b1;
`endif
    end
  end

`ifdef BNN_LOAD_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_csum <= '0;
    else if (w_go)
      r_csum <= '0;
    else if (wr_en)
      r_csum <= r_csum ^ w_byte;
  end
`endif

  assign wr_en   = ena & ~w_abort & (r_state == S_WRITE);
  assign wr_addr = r_cnt;
  assign wr_data = w_byte;
  assign busy    = (r_state != S_IDLE);
  assign done    = ena & ~w_abort & (r_state == S_DONE);

  assign weights_valid = r_wv;
  assign err           = r_err;

endmodule

// File: doc/bnn_load_ctrl.md
BNN_LOAD_CTRL -- requirements
Module: bnn_load_ctrl

Interface
REQ-001 Parameter NUM_NEURONS, default 12: number of neuron weight bytes per load session (8 layer-1 plus 4 layer-2).
REQ-002 Parameter ADDR_W, default 4: width of wr_addr; SHALL satisfy 2**ADDR_W >= NUM_NEURONS.
REQ-003 clk  in  1: single clock; all state updates on its rising edge.
REQ-004 reset  in  1: asynchronous, active-high reset.
REQ-005 ena  in  1: block enable; when low, all state holds and nib_ready=0.
REQ-006 start  in  1: level sampled each cycle; begins a load session from IDLE.
REQ-007 abort  in  1: terminates an active session.
REQ-008 nib_valid  in  1: a weight nibble is presented.
REQ-009 nib_data  in  4: weight nibble; low nibble first, then high nibble.
REQ-010 nib_ready  out  1: controller accepts a nibble this cycle.
REQ-011 wr_en  out  1: one-cycle write strobe to the weight register file.
REQ-012 wr_addr  out  ADDR_W: neuron index being written.
REQ-013 wr_data  out  8: assembled weight byte {high, low}.
REQ-014 busy  out  1: high in every state except IDLE.
REQ-015 done  out  1: one-cycle pulse on successful session completion.
REQ-016 weights_valid  out  1: a complete, unaborted load has occurred.
REQ-017 err  out  1: sticky error flag.

Function
REQ-018 States: IDLE, LO, HI, WRITE, CHK_LO, CHK_HI, DONE; CHK_* exist only with BNN_LOAD_CHECKSUM_EN.
REQ-019 A handshake SHALL occur when nib_valid && nib_ready && ena; nib_ready=1 only in LO, HI, CHK_LO and CHK_HI.
REQ-020 IDLE: start && ena -> LO; counter=0; weights_valid:=0; err:=0.
REQ-021 LO: on handshake, nib_data is latched as the low nibble -> HI.
REQ-022 HI: on handshake, the byte is latched -> WRITE.
REQ-023 WRITE: wr_en=1 for exactly this cycle, with wr_addr=counter and wr_data=latched byte; then counter+1.
REQ-024 WRITE exit: -> LO if counter<NUM_NEURONS-1; otherwise -> DONE, or -> CHK_LO when the checksum feature is compiled in.
REQ-025 DONE: done=1 for one cycle; weights_valid:=1 -> IDLE.
REQ-026 Write latency: wr_en is asserted exactly 1 cycle after the high-nibble handshake.
REQ-027 No-stall session timing: IDLE->LO edge, then 3 cycles per neuron; done is asserted in cycle 3*NUM_NEURONS+1 after the start edge (37 at default).
REQ-028 abort && ena in any non-IDLE state: -> IDLE on the next edge.
REQ-029 On abort, no wr_en is issued in the abort cycle, even in WRITE.
REQ-030 On abort, weights_valid stays 0 and err:=1.
REQ-031 abort has priority over a same-cycle handshake and over the DONE transition.
REQ-032 start while busy SHALL be ignored; abort in IDLE SHALL be ignored.
REQ-033 ena=0 SHALL freeze the state, the counter and the latched nibbles; wr_en and done SHALL be 0 while ena=0.
REQ-034 The counter SHALL never exceed NUM_NEURONS-1 and SHALL never wrap.

Reset
REQ-035 On reset, the state SHALL go to IDLE, and counter and nibble latches SHALL clear.
REQ-036 On reset, wr_en=0, wr_addr=0, wr_data=0, nib_ready=0, busy=0, done=0 and err=0.
REQ-037 On reset, weights_valid=1; reset weights are the datapath's built-in defaults.
REQ-038 Reset asserted mid-session SHALL take effect immediately and asynchronously, and SHALL suppress any pending write.

Configuration
REQ-039 Macro BNN_LOAD_CHECKSUM_EN defined: the controller keeps a running 8-bit XOR of all written bytes, cleared at start.
REQ-040 With BNN_LOAD_CHECKSUM_EN, two extra nibbles (CHK_LO, CHK_HI) form the expected checksum.
REQ-041 Checksum match -> DONE; mismatch -> err:=1, weights_valid stays 0, no done pulse -> IDLE.
REQ-042 Macro BNN_LOAD_CHECKSUM_EN undefined: no CHK states, no checksum register; WRITE of the last neuron goes directly to DONE.

Structure
REQ-043 A shared package bnn_pkg SHALL hold the NUM_NEURONS default, the weight width (8), the nibble width (4) and the state enumeration.
REQ-044 One sub-module, bnn_nibble_packer, SHALL hold the low/high nibble latch and byte assembly; the FSM and counter stay in bnn_load_ctrl.

Verification
REQ-045 Reset, then start with 24 nibbles, valid always high -> 12 wr_en pulses, addr 0..11, data e.g. 8'hA0 from nibbles 0,A, done at cycle 37, weights_valid=1.
REQ-046 Random nib_valid gaps and ena low for 5 cycles mid-session -> identical write sequence, no extra or lost writes, no strobe while ena=0.
REQ-047 abort asserted in WRITE for addr 5 -> no write to addr 5, IDLE next cycle, err=1, weights_valid=0; a fresh start clears err.
REQ-048 start pulsed at addr 3 during a session -> ignored; reset asserted at addr 7 -> immediate IDLE, all outputs at reset values.
REQ-049 With BNN_LOAD_CHECKSUM_EN: correct XOR trailer -> done; trailer XOR 8'h01 -> err=1, no done, weights_valid=0.
